// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fq_mem.sv
// Fetch queue storage: register array, synchronous write, asynchronous read.
module ifu_fq_mem
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = $bits(fetch_entry_t),
    localparam int unsigned IdxW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IdxW-1:0]  widx_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IdxW-1:0]  ridx_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are don't-care after reset; occupancy lives in the pointers.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ifu_fetch_queue.sv
// IF->ID decoupling FIFO with valid/ready on both sides, flush and carried prediction bit.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      INST_W   = 32,
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_NOP,
    localparam int unsigned     CntW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              inst_valid_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              pred_taken_i,
    output logic              inst_ready_o,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              pred_taken_o,
    input  logic              dec_ready_i,
    output logic [CntW-1:0]   count_o
);

    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam int unsigned PtrW   = IdxW + 1;
    localparam int unsigned EntryW = INST_W + ADDR_W + 1;

    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              empty, full, push, pop;
    logic [EntryW-1:0] wdata, head;

    // Wrap bit distinguishes full from empty when index bits match.
    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[IdxW-1:0] == wr_ptr_q[IdxW-1:0]) &&
                   (rd_ptr_q[IdxW] != wr_ptr_q[IdxW]);

    assign push = inst_valid_i & ~full & ~flush_i;
    assign pop  = ~empty & dec_ready_i & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wdata = {pred_taken_i, inst_addr_i, inst_i};

    ifu_fq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .widx_i  (wr_ptr_q[IdxW-1:0]),
        .wdata_i (wdata),
        .ridx_i  (rd_ptr_q[IdxW-1:0]),
        .rdata_o (head)
    );

    // Outputs depend only on registered pointers and stored data.
    assign inst_ready_o = ~full;
    assign inst_valid_o = ~empty;
    assign inst_o       = empty ? NOP_INST : head[INST_W-1:0];
    assign inst_addr_o  = empty ? ADDR_W'(ZeroWord) : head[INST_W +: ADDR_W];
    assign pred_taken_o = empty ? 1'b0 : head[EntryW-1];
    assign count_o      = count_q;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed self-checking bench for ifu_fetch_queue (DEPTH=4).
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        pred_taken_i;
    logic        inst_ready_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        pred_taken_o;
    logic        dec_ready_i;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    ifu_fetch_queue #(
        .DEPTH    (4),
        .INST_W   (32),
        .ADDR_W   (32),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .pred_taken_i (pred_taken_i),
        .inst_ready_o (inst_ready_o),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .pred_taken_o (pred_taken_o),
        .dec_ready_i  (dec_ready_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    // Entry k: inst 0x100+k, address 0x8000_0000+4k, prediction = k odd.
    function automatic logic [64:0] ent(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {kk[0], 32'h8000_0000 + (kk << 2), 32'h0000_0100 + kk};
    endfunction

    task automatic offer(input logic v, input int k);
        logic [64:0] e;
        e = ent(k);
        inst_valid_i = v;
        pred_taken_i = e[64];
        inst_addr_i  = e[63:32];
        inst_i       = e[31:0];
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_i = 1'b0;
        dec_ready_i = 1'b0;
        offer(1'b0, 0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({inst_valid_o, inst_ready_o, inst_o, inst_addr_o, pred_taken_o, count_o} !==
            {1'b0, 1'b1, 32'h13, 32'h0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%b inst=%h addr=%h p=%b cnt=%0d, want 0 1 00000013 0 0 0",
                     inst_valid_o, inst_ready_o, inst_o, inst_addr_o, pred_taken_o, count_o);
        end
    endtask

    task automatic test_single_push();
        do_reset();
        inst_valid_i = 1'b1;
        inst_i = 32'h0000_0093;
        inst_addr_i = 32'h8000_0000;
        pred_taken_i = 1'b0;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0 || inst_o !== 32'h13) begin
            errors++;
            $display("FAIL no_bypass: got v=%b inst=%h, want 0 00000013", inst_valid_o, inst_o);
        end
        cycle();
        inst_valid_i = 1'b0;
        checks++;
        if ({inst_valid_o, inst_o, inst_addr_o, count_o} !== {1'b1, 32'h93, 32'h8000_0000, 3'd1}) begin
            errors++;
            $display("FAIL single_push: got v=%b inst=%h addr=%h cnt=%0d, want 1 00000093 80000000 1",
                     inst_valid_o, inst_o, inst_addr_o, count_o);
        end
    endtask

    task automatic test_fill_and_drain();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            offer(1'b1, k);
            cycle();
        end
        checks++;
        if (inst_ready_o !== 1'b0 || count_o !== 3'd4) begin
            errors++;
            $display("FAIL full: got ready=%b cnt=%0d, want 0 4", inst_ready_o, count_o);
        end
        checks++;
        if ({pred_taken_o, inst_addr_o, inst_o} !== ent(1)) begin
            errors++;
            $display("FAIL full_head: got %h, want %h", {pred_taken_o, inst_addr_o, inst_o}, ent(1));
        end
        // Entry 5 still offered; pop only since the queue is full.
        dec_ready_i = 1'b1;
        cycle();
        checks++;
        if (count_o !== 3'd3 || inst_ready_o !== 1'b1 || {pred_taken_o, inst_addr_o, inst_o} !== ent(2)) begin
            errors++;
            $display("FAIL pop_from_full: got cnt=%0d ready=%b head=%h, want 3 1 %h",
                     count_o, inst_ready_o, {pred_taken_o, inst_addr_o, inst_o}, ent(2));
        end
        cycle();
        offer(1'b0, 0);
        checks++;
        if (count_o !== 3'd3 || {pred_taken_o, inst_addr_o, inst_o} !== ent(3)) begin
            errors++;
            $display("FAIL push_pop: got cnt=%0d head=%h, want 3 %h",
                     count_o, {pred_taken_o, inst_addr_o, inst_o}, ent(3));
        end
        for (int k = 4; k <= 5; k++) begin
            cycle();
            checks++;
            if ({inst_valid_o, pred_taken_o, inst_addr_o, inst_o} !== {1'b1, ent(k)}) begin
                errors++;
                $display("FAIL drain_%0d: got v=%b head=%h, want 1 %h",
                         k, inst_valid_o, {pred_taken_o, inst_addr_o, inst_o}, ent(k));
            end
        end
        cycle();
        dec_ready_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || count_o !== 3'd0 || inst_o !== 32'h13) begin
            errors++;
            $display("FAIL drained_empty: got v=%b cnt=%0d inst=%h, want 0 0 00000013",
                     inst_valid_o, count_o, inst_o);
        end
    endtask

    task automatic test_hold_stable();
        do_reset();
        offer(1'b1, 20);
        cycle();
        offer(1'b1, 21);
        cycle();
        offer(1'b1, 22);
        cycle();
        offer(1'b0, 0);
        checks++;
        if (count_o !== 3'd3 || {pred_taken_o, inst_addr_o, inst_o} !== ent(20)) begin
            errors++;
            $display("FAIL hold_stable: got cnt=%0d head=%h, want 3 %h",
                     count_o, {pred_taken_o, inst_addr_o, inst_o}, ent(20));
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        do_reset();
        offer(1'b1, 0);
        cycle();
        dec_ready_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            offer(1'b1, k);
            cycle();
            checks++;
            if (count_o !== 3'd1 || {pred_taken_o, inst_addr_o, inst_o} !== ent(k)) begin
                errors++;
                $display("FAIL stream_%0d: got cnt=%0d head=%h, want 1 %h",
                         k, count_o, {pred_taken_o, inst_addr_o, inst_o}, ent(k));
            end
        end
        offer(1'b0, 0);
        cycle();
        dec_ready_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL stream_end: got v=%b cnt=%0d, want 0 0", inst_valid_o, count_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 30; k < 33; k++) begin
            offer(1'b1, k);
            cycle();
        end
        flush_i = 1'b1;
        dec_ready_i = 1'b1;
        offer(1'b1, 33);
        cycle();
        flush_i = 1'b0;
        dec_ready_i = 1'b0;
        offer(1'b0, 0);
        checks++;
        if ({inst_valid_o, inst_ready_o, inst_o, inst_addr_o, pred_taken_o, count_o} !==
            {1'b0, 1'b1, 32'h13, 32'h0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL flush: got v=%b r=%b inst=%h addr=%h p=%b cnt=%0d, want 0 1 00000013 0 0 0",
                     inst_valid_o, inst_ready_o, inst_o, inst_addr_o, pred_taken_o, count_o);
        end
        cycle();
        checks++;
        if (inst_valid_o !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL flush_input_dropped: got v=%b cnt=%0d, want 0 0", inst_valid_o, count_o);
        end
        offer(1'b1, 35);
        cycle();
        offer(1'b0, 0);
        checks++;
        if (count_o !== 3'd1 || {pred_taken_o, inst_addr_o, inst_o} !== ent(35)) begin
            errors++;
            $display("FAIL push_after_flush: got cnt=%0d head=%h, want 1 %h",
                     count_o, {pred_taken_o, inst_addr_o, inst_o}, ent(35));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        offer(1'b1, 40);
        cycle();
        offer(1'b1, 41);
        cycle();
        offer(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({inst_valid_o, inst_ready_o, inst_o, inst_addr_o, pred_taken_o, count_o} !==
            {1'b0, 1'b1, 32'h13, 32'h0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b r=%b inst=%h addr=%h p=%b cnt=%0d, want 0 1 00000013 0 0 0",
                     inst_valid_o, inst_ready_o, inst_o, inst_addr_o, pred_taken_o, count_o);
        end
        rst = 1'b0;
        offer(1'b1, 43);
        cycle();
        offer(1'b0, 0);
        checks++;
        if (count_o !== 3'd1 || {inst_valid_o, pred_taken_o, inst_addr_o, inst_o} !== {1'b1, ent(43)}) begin
            errors++;
            $display("FAIL push_after_reset: got cnt=%0d v=%b head=%h, want 1 1 %h",
                     count_o, inst_valid_o, {pred_taken_o, inst_addr_o, inst_o}, ent(43));
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_and_drain();
        test_hold_stable();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
